// File: rtl/operand_fetch.sv
// rtl/operand_fetch.sv - operand fetch stage: register read, writeback forwarding,
// pending-write scoreboard with RAW/WAW stall, and the execute pipeline register.
module operand_fetch #(
  parameter int addr_width_p = 6,
  parameter int op_width_p   = 8
) (
  input  logic                    clk,
  input  logic                    reset_n_i,

  input  logic                    dec_valid_i,
  output logic                    dec_ready_o,
  input  logic [op_width_p-1:0]   dec_op_i,
  input  logic [addr_width_p-1:0] dec_rs_addr_i,
  input  logic [addr_width_p-1:0] dec_rd_addr_i,
  input  logic                    dec_wen_i,

  output logic [addr_width_p-1:0] rf_rs_addr_o,
  output logic [addr_width_p-1:0] rf_rd_addr_o,
  input  logic [31:0]             rf_rs_val_i,
  input  logic [31:0]             rf_rd_val_i,

  input  logic                    wb_valid_i,
  input  logic [addr_width_p-1:0] wb_addr_i,
  input  logic [31:0]             wb_data_i,

  output logic                    ex_valid_o,
  input  logic                    ex_ready_i,
  output logic [op_width_p-1:0]   ex_op_o,
  output logic [31:0]             ex_rs_val_o,
  output logic [31:0]             ex_rd_val_o,
  output logic [addr_width_p-1:0] ex_rd_addr_o,
  output logic                    ex_wen_o,
  output logic [15:0]             stall_cnt_o
);

  localparam int num_regs_lp = 1 << addr_width_p;

  logic [num_regs_lp-1:0]  pending_r;
  logic [num_regs_lp-1:0]  pending_set;
  logic [num_regs_lp-1:0]  pending_clr;

  logic                    ex_valid_r;
  logic [op_width_p-1:0]   ex_op_r;
  logic [31:0]             ex_rs_val_r;
  logic [31:0]             ex_rd_val_r;
  logic [addr_width_p-1:0] ex_rd_addr_r;
  logic                    ex_wen_r;
  logic [15:0]             stall_cnt_r;

  logic                    fwd_rs;
  logic                    fwd_rd;
  logic                    hz_rs;
  logic                    hz_rd;
  logic                    hazard;
  logic                    slot_free;
  logic                    fire;
  logic [31:0]             rs_val;
  logic [31:0]             rd_val;

  assign rf_rs_addr_o = dec_rs_addr_i;
  assign rf_rd_addr_o = dec_rd_addr_i;

  // A writeback landing this cycle both supplies the operand and retires the
  // pending write, so it must not be treated as a hazard.
  assign fwd_rs = wb_valid_i & (wb_addr_i == dec_rs_addr_i);
  assign fwd_rd = wb_valid_i & (wb_addr_i == dec_rd_addr_i);
  assign rs_val = fwd_rs ? wb_data_i : rf_rs_val_i;
  assign rd_val = fwd_rd ? wb_data_i : rf_rd_val_i;

  assign hz_rs  = pending_r[dec_rs_addr_i] & ~fwd_rs;
  assign hz_rd  = pending_r[dec_rd_addr_i] & ~fwd_rd;
  assign hazard = dec_valid_i & (hz_rs | hz_rd);

  assign slot_free   = ~ex_valid_r | ex_ready_i;
  assign dec_ready_o = slot_free & ~(hz_rs | hz_rd);
  assign fire        = dec_valid_i & dec_ready_o;

  always_comb begin
    pending_set = '0;
    pending_clr = '0;
    if (fire && dec_wen_i) begin
      pending_set[dec_rd_addr_i] = 1'b1;
    end
    if (wb_valid_i) begin
      pending_clr[wb_addr_i] = 1'b1;
    end
  end

  // Set is OR-ed after the clear so a same-register issue/writeback keeps the bit.
  always_ff @(posedge clk) begin
    if (!reset_n_i) begin
      pending_r <= '0;
    end else begin
      pending_r <= (pending_r & ~pending_clr) | pending_set;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n_i) begin
      ex_valid_r   <= 1'b0;
      ex_op_r      <= '0;
      ex_rs_val_r  <= '0;
      ex_rd_val_r  <= '0;
      ex_rd_addr_r <= '0;
      ex_wen_r     <= 1'b0;
    end else if (fire) begin
      ex_valid_r   <= 1'b1;
      ex_op_r      <= dec_op_i;
      ex_rs_val_r  <= rs_val;
      ex_rd_val_r  <= rd_val;
      ex_rd_addr_r <= dec_rd_addr_i;
      ex_wen_r     <= dec_wen_i;
    end else if (ex_ready_i) begin
      ex_valid_r   <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n_i) begin
      stall_cnt_r <= '0;
    end else if (hazard && (stall_cnt_r != 16'hFFFF)) begin
      stall_cnt_r <= stall_cnt_r + 16'd1;
    end
  end

  assign ex_valid_o   = ex_valid_r;
  assign ex_op_o      = ex_op_r;
  assign ex_rs_val_o  = ex_rs_val_r;
  assign ex_rd_val_o  = ex_rd_val_r;
  assign ex_rd_addr_o = ex_rd_addr_r;
  assign ex_wen_o     = ex_wen_r;
  assign stall_cnt_o  = stall_cnt_r;

endmodule
